or1200_wb_arbiter: RTL and testbench
====================================

# or1200_wb_arbiter

Two-master, one-slave Wishbone arbiter that shares the SOPC's single memory/peripheral slave port between the OR1200 instruction-fetch master (M0) and data master (M1). It sits between the CPU's two Wishbone interfaces and the slave side of `or1200_sopc`. It registers a grant, holds it for the whole `cyc` of the granted master, alternates fairly under contention, and can optionally abort stalled cycles with a bus error.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is DW/8.
- `TIMEOUT`, 255: stall limit in cycles, 1..65535. Used only with the timeout feature.
- `clk_i` input 1: single system clock, rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` input 1: M0 (instruction) request qualifiers.
- `m0_sel_i` input DW/8; `m0_adr_i` input AW; `m0_dat_i` input DW: M0 request payload.
- `m0_dat_o` output DW: read data returned to M0.
- `m0_ack_o`, `m0_err_o` output 1: M0 termination.
- `m1_*`: the same set for M1 (data).
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1: request qualifiers to the slave.
- `s_sel_o` output DW/8; `s_adr_o` output AW; `s_dat_o` output DW: request payload to the slave.
- `s_dat_i` input DW; `s_ack_i`, `s_err_i` input 1: slave response.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE. `last` (last-granted bit) resets to 1, so M0 wins the first contention.
- IDLE:
  - Only M0 `cyc` high -> GNT0. Only M1 `cyc` high -> GNT1.
  - Both high -> grant the master that is not `last`.
- GNTx holds while `mx_cyc_i`=1. Wishbone burst and RMW sequences are never split.
- On `mx_cyc_i`=0 in GNTx:
  - Other master's `cyc` high -> switch directly to the other GNT state. No IDLE bubble.
  - Otherwise -> IDLE.
  - `last` updates to x on every grant entry.
- Slave outputs mux the granted master's inputs combinationally from the registered state. In IDLE all slave qualifiers are 0 and payload is 0.
- `s_ack_i`/`s_err_i` are routed only to the granted master. The non-granted master's `ack`/`err` are always 0.
- `m0_dat_o` = `m1_dat_o` = `s_dat_i` (broadcast). Masters qualify the data with their own `ack`.
- `s_ack_i` and `s_err_i` both high in one cycle: pass both. The slave is responsible for that condition; it is not filtered here.
- A master dropping `cyc` mid-transfer without `ack` is a legal abort. Grant is released the same way as a normal end.

## Timing
- Request to grant: 1 cycle. `mx_cyc_i` rises in cycle N, grant state changes at the edge ending N, and `s_cyc_o` is high in N+1.
- Grant hand-over on release: 1 cycle after the releasing master's `cyc` is low.
- Response path (`ack`/`err`/`dat`): combinational, 0 cycles.
- Reset is asynchronous. Asserting `rst_ni` mid-transfer drops all outputs to 0 immediately and forces IDLE, `last`=1, stall counter 0.
- Reset value of every output: 0.

## Configuration
- Macro: `OR1200_WB_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit stall counter increments each cycle that `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0.
  - It clears on `ack`/`err`, on a grant change, or when `s_stb_o`=0.
  - When the counter equals `TIMEOUT`: the granted master receives `err_o`=1 for exactly that cycle, `s_cyc_o`/`s_stb_o` are forced to 0 for that cycle, and the counter clears.
  - Grant is kept until the master drops `cyc`.
- Undefined: no counter. `err_o` is pure pass-through of `s_err_i`, and a stalled slave hangs the bus indefinitely.

## Structure
- Shared package `or1200_wb_pkg`:
  - State enum {IDLE, GNT0, GNT1}.
  - Default `AW`/`DW` constants.
  - Timeout counter width constant (16).
- Sub-module `or1200_wb_arb_timer`: the stall counter, wrapped entirely in `OR1200_WB_ARB_TIMEOUT_EN`.
- The FSM and muxes stay in the top.

## Test plan
- Reset: hold `rst_ni`=0 with both `cyc` high -> all outputs 0. Release -> GNT0 one cycle later, and `s_adr_o` = `m0_adr_i` (e.g. 0x0000_0100).
- Single M1 write: M1 `adr`=0x0000_2000, `dat`=0xDEADBEEF, `we`=1, `sel`=0xF; slave acks on the 3rd cycle -> `s_*` mirrors M1, `m1_ack_o`=1 for one cycle, `m0_ack_o`=0 throughout.
- Contention: both `cyc` rise in the same cycle, each doing 1-beat cycles back to back -> grants alternate M0, M1, M0, M1 with no IDLE cycle between them.
- Burst lock: M0 holds `cyc` for 4 acked beats while M1 requests -> M1 is not granted until the cycle after M0's `cyc` falls.
- Read routing: `s_dat_i`=0x1234_5678 with `ack` during GNT1 -> `m1_ack_o`=1, `m1_dat_o`=0x1234_5678, `m0_ack_o`=0.
- Timeout (macro defined, `TIMEOUT`=8): M0 strobes and the slave never acks -> `m0_err_o`=1 exactly 8 cycles after `s_stb_o` rises, `s_stb_o`=0 in that cycle. Without the macro: no `err` after 1000 cycles.

Source files
------------

// File: rtl/or1200_wb_pkg.sv
// or1200_wb_pkg: shared types and constants for the OR1200 Wishbone arbiter.
// Rev 1.0
`default_nettype none

package or1200_wb_pkg;

  localparam int WB_AW  = 32;
  localparam int WB_DW  = 32;
  localparam int TMO_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/or1200_wb_arb_timer.sv
// or1200_wb_arb_timer: stall counter, built only with OR1200_WB_ARB_TIMEOUT_EN.
// Rev 1.0
`default_nettype none

`ifdef OR1200_WB_ARB_TIMEOUT_EN
module or1200_wb_arb_timer
  import or1200_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stb,
  input  logic resp,
  input  logic gnt_change,
  output logic expire
);

  logic [TMO_CW-1:0] count;

  assign expire = (count == TMO_CW'(TIMEOUT));

  // Expiry clears the count so a still-stalled master gets a fresh window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (!stb || resp || gnt_change || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/or1200_wb_arbiter.sv
// or1200_wb_arbiter: two-master/one-slave Wishbone arbiter, cycle-locked grant,
// alternating priority; stall timeout under OR1200_WB_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module or1200_wb_arbiter
  import or1200_wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  arb_state_t state;
  logic       last;
  logic       expire;

  // Winner under contention is the master that was not granted most recently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OR1200_WB_ARB_TIMEOUT_EN
  logic raw_stb;
  logic gnt_change;

  always_comb begin
    raw_stb    = 1'b0;
    gnt_change = 1'b0;
    case (state)
      IDLE: gnt_change = m0_cyc_i | m1_cyc_i;
      GNT0: begin
        raw_stb    = m0_stb_i;
        gnt_change = ~m0_cyc_i;
      end
      GNT1: begin
        raw_stb    = m1_stb_i;
        gnt_change = ~m1_cyc_i;
      end
      default: gnt_change = 1'b1;
    endcase
  end

  or1200_wb_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .stb       (raw_stb),
    .resp      (s_ack_i | s_err_i),
    .gnt_change(gnt_change),
    .expire    (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
`endif

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~expire;
        s_stb_o  = m0_stb_i & ~expire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | expire;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~expire;
        s_stb_o  = m1_stb_i & ~expire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | expire;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; gating by reset keeps every output at 0 while held.
  assign m0_dat_o = rst_ni ? s_dat_i : '0;
  assign m1_dat_o = rst_ni ? s_dat_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_or1200_wb_arbiter.sv
// tb_or1200_wb_arbiter: scoreboard bench for the two-master Wishbone arbiter.
`default_nettype none

module tb_or1200_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack, s_err;

  logic        slave_en = 1'b0;
  int          lat = 1;
  int          wcnt = 0;
  logic [31:0] rd_data = '0;
  int          cyc_n = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb[$];
  int   ack_t[$];

  or1200_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .s_err_i(s_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign s_dat_i = s_ack ? rd_data : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: acks after 'lat' cycles of continuous strobe.
  initial begin
    s_ack = 1'b0;
    s_err = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (slave_en && s_cyc_o && s_stb_o) begin
        if (wcnt >= lat - 1) begin
          s_ack = 1'b1;
          wcnt  = 0;
        end else begin
          s_ack = 1'b0;
          wcnt++;
        end
      end else begin
        s_ack = 1'b0;
        wcnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ack_exclusive", {31'b0, m0_ack_o & m1_ack_o}, 32'h0);
      if (m0_ack_o || m1_ack_o) begin
        exp_t e;
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_master", {31'b0, m1_ack_o}, e.m[31:0]);
          check("s_adr", s_adr_o, e.adr);
          check("s_we", {31'b0, s_we_o}, {31'b0, e.we});
          check("s_sel", {28'b0, s_sel_o}, 32'hF);
          if (e.we) check("s_dat", s_dat_o, e.dat);
          check("m0_dat_o", m0_dat_o, e.rdat);
          check("m1_dat_o", m1_dat_o, e.rdat);
        end
        ack_t.push_back(cyc_n);
      end
    end
  end

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = c ? 4'hF : 4'h0; m0_adr = a; m0_dat = d;
    end else begin
      m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = c ? 4'hF : 4'h0; m1_adr = a; m1_dat = d;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  task automatic push_exp(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [31:0] r);
    exp_t e;
    e.m = m; e.adr = a; e.dat = d; e.we = w; e.rdat = r;
    sb.push_back(e);
  endtask

  task automatic m_cycle(input int m, input int beats, input logic [31:0] adr,
                         input logic [31:0] dat, input logic we);
    int n;
    @(posedge clk); #1;
    drive(m, 1'b1, 1'b1, we, adr, dat);
    for (int b = 0; b < beats; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack_of(m) && n < 100);
      check("ack_seen", {31'b0, ack_of(m)}, 32'h1);
      @(posedge clk); #1;
      if (b == beats - 1) drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else drive(m, 1'b1, 1'b1, we, adr + 32'(4 * (b + 1)), dat + 32'(b + 1));
    end
  endtask

  task automatic check_gaps(input string tag, input int first, input int exp_gap[$]);
    for (int i = 0; i < exp_gap.size(); i++)
      check(tag, 32'(ack_t[first+i+1] - ack_t[first+i]), 32'(exp_gap[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, errs;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_s_cyc", {31'b0, s_cyc_o}, 32'h0);
    check("rst_s_stb", {31'b0, s_stb_o}, 32'h0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_acks", {28'b0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
    check("rst_dat", m0_dat_o | m1_dat_o, 32'h0);
    rst_n = 1'b1;
    #1 check("rel_s_cyc", {31'b0, s_cyc_o}, 32'h0);
    @(negedge clk);
    check("gnt0_s_cyc", {31'b0, s_cyc_o}, 32'h1);
    check("gnt0_s_adr", s_adr_o, 32'h0000_0100);
    // Asynchronous reset mid-transfer.
    #2 rst_n = 1'b0;
    #1 check("arst_s_cyc", {31'b0, s_cyc_o}, 32'h0);
    check("arst_s_adr", s_adr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rearb_s_adr", s_adr_o, 32'h0000_0100);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("idle_s_cyc", {31'b0, s_cyc_o}, 32'h0);

    slave_en = 1'b1;
    lat = 3;
    push_exp(1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 32'h0);
    m_cycle(1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1);
    check("wr_sb_empty", 32'(sb.size()), 32'h0);

    lat = 1;
    ack_t.delete();
    push_exp(0, 32'h0000_0A00, 32'h0000_00A0, 1'b1, 32'h0);
    push_exp(1, 32'h0000_0B00, 32'h0000_00B0, 1'b1, 32'h0);
    push_exp(0, 32'h0000_0C00, 32'h0000_00C0, 1'b1, 32'h0);
    push_exp(1, 32'h0000_0D00, 32'h0000_00D0, 1'b1, 32'h0);
    fork
      begin
        m_cycle(0, 1, 32'h0000_0A00, 32'h0000_00A0, 1'b1);
        m_cycle(0, 1, 32'h0000_0C00, 32'h0000_00C0, 1'b1);
      end
      begin
        m_cycle(1, 1, 32'h0000_0B00, 32'h0000_00B0, 1'b1);
        m_cycle(1, 1, 32'h0000_0D00, 32'h0000_00D0, 1'b1);
      end
    join
    check("alt_sb_empty", 32'(sb.size()), 32'h0);
    check("alt_acks", 32'(ack_t.size()), 32'h4);
    if (ack_t.size() == 4) check_gaps("alt_gap", 0, '{2, 2, 2});

    ack_t.delete();
    for (int b = 0; b < 4; b++)
      push_exp(0, 32'h0000_3000 + 32'(4 * b), 32'h0000_0100 + 32'(b), 1'b1, 32'h0);
    push_exp(1, 32'h0000_5000, 32'h0000_0500, 1'b1, 32'h0);
    fork
      m_cycle(0, 4, 32'h0000_3000, 32'h0000_0100, 1'b1);
      begin
        @(posedge clk);
        m_cycle(1, 1, 32'h0000_5000, 32'h0000_0500, 1'b1);
      end
    join
    check("burst_sb_empty", 32'(sb.size()), 32'h0);
    check("burst_acks", 32'(ack_t.size()), 32'h5);
    if (ack_t.size() == 5) check_gaps("burst_gap", 0, '{1, 1, 1, 2});

    rd_data = 32'h1234_5678;
    push_exp(1, 32'h0000_4000, 32'h0, 1'b0, 32'h1234_5678);
    m_cycle(1, 1, 32'h0000_4000, 32'h0, 1'b0);
    check("rd_sb_empty", 32'(sb.size()), 32'h0);
    rd_data = 32'h0;

    slave_en = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0);
`ifdef OR1200_WB_ARB_TIMEOUT_EN
    t0 = -1;
    t1 = -1;
    n = 0;
    while (t1 < 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (t0 < 0 && s_stb_o) t0 = cyc_n;
      if (m0_err_o) t1 = cyc_n;
    end
    check("tmo_latency", 32'(t1 - t0), 32'h8);
    check("tmo_stb_low", {30'b0, s_stb_o, s_cyc_o}, 32'h0);
    check("tmo_m1_err", {31'b0, m1_err_o}, 32'h0);
    @(negedge clk);
    check("tmo_err_pulse", {31'b0, m0_err_o}, 32'h0);
    check("tmo_regrant", {31'b0, s_stb_o}, 32'h1);
`else
    t0 = 0;
    t1 = 0;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m0_err_o || m1_err_o) errs++;
    end
    check("no_tmo_err", 32'(errs), 32'h0);
    check("no_tmo_stb", {31'b0, s_stb_o}, 32'h1);
`endif
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("end_idle", {31'b0, s_cyc_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
